seq_bin_to_bcd: RTL and testbench
=================================

Name: seq_bin_to_bcd

Overview:
- Multi-cycle, parametrised binary-to-BCD converter using the shift-add-3 (double-dabble) method, one or more shift steps per clock.
- Replaces wide combinational converters where timing closure or LUT count matters, e.g. score, coordinate and counter displays feeding the 7-segment and VGA text paths.
- Adds a start/busy/done handshake, optional signed input and a selectable steps-per-cycle rate.
- Keeps the tri-state output-enable behaviour so several converters can share a display bus.

Parameters:
- BIN_WIDTH, 8: width of binary input in bits; must be at least 2.
- DIGITS, (BIN_WIDTH*301)/1000+1: number of BCD output digits; the default covers 2^BIN_WIDTH-1.
- SHIFTS_PER_CYCLE, 1: double-dabble steps executed per clock; must divide BIN_WIDTH exactly (elaboration error otherwise).
- SIGNED_MODE, 0: 0 treats bin_in as unsigned; 1 treats it as two's complement and converts its magnitude.

Ports:
- clk, input, 1: system clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request conversion of bin_in; sampled only while busy=0.
- bin_in, input, BIN_WIDTH: value to convert; captured on the accepting edge.
- bcd_oe, input, 1: output enable for bcd_out and sign_out.
- busy, output, 1: conversion in progress.
- done, output, 1: one-cycle pulse; result valid.
- sign_out, output, 1: 1 = captured value was negative (SIGNED_MODE=1 only, else constant 0); Z when bcd_oe=0.
- bcd_out, output, 4*DIGITS: packed BCD, digit 0 in bits [3:0]; Z when bcd_oe=0.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, busy=0, done=0, internal result register=0, sign register=0, step counter=0. Outputs read 0 if bcd_oe=1.
- Release of reset is synchronous to clk.
- FSM states: IDLE, SHIFT, FINISH.
  - IDLE: start=1 at an edge → capture operand, clear BCD scratch, step counter=0, go to SHIFT, busy=1.
  - In SIGNED_MODE=1, operand = |bin_in| as an unsigned BIN_WIDTH value, so the most negative value converts correctly (0x80 → 128). sign = bin_in MSB.
  - SHIFT: each edge performs SHIFTS_PER_CYCLE steps. Each step: for every digit >= 5 add 3, then shift {scratch, operand} left by 1. Step counter advances by SHIFTS_PER_CYCLE.
  - When the counter reaches BIN_WIDTH (after N = BIN_WIDTH/SHIFTS_PER_CYCLE edges), go to FINISH.
  - FINISH is a combinational exit, not an extra cycle: on the Nth SHIFT edge, the result register and sign register load, done=1, busy=0, and the FSM returns to IDLE.
- Latency: accepting edge E0; done high during the cycle after edge EN; busy high from E0 to EN.
  - SHIFTS_PER_CYCLE=1, BIN_WIDTH=8: done 8 cycles after the capture edge.
- Result register holds its value until the next done; it is never partially updated.
- start while busy=1: ignored; the in-flight conversion is unaffected.
- start=1 in the cycle done=1 (busy already 0): accepted, giving back-to-back conversions with period N+1 cycles... (one IDLE-accept edge plus N shift edges).
- bin_in changes after capture: no effect on the in-flight conversion.
- Reset mid-conversion: abort immediately; result register cleared to 0; no done pulse.
- bcd_oe: purely combinational gate on the outputs; it does not affect the FSM. busy and done are always driven.
- Width rules:
  - Scratch register is 4*DIGITS bits; add-3 is applied per 4-bit digit, modulo 16.
  - If DIGITS is overridden smaller than required, upper digits are truncated silently.

Test Plan:
- BIN_WIDTH=8, unsigned, start with bin_in=0xFF → after 8 clocks done=1 for exactly one cycle; bcd_out=0x255; busy high for exactly 8 cycles.
- bin_in=0x00 → bcd_out=0x000; then 0x63 back-to-back (start in the done cycle) → bcd_out=0x099 with no idle gap.
- SIGNED_MODE=1: 0x80 → sign_out=1, bcd_out=0x128; 0x7F → sign_out=0, 0x127; 0xFF → sign_out=1, 0x001.
- BIN_WIDTH=16, SHIFTS_PER_CYCLE=4: 0xFFFF → done after 4 cycles, bcd_out=0x65535; a start pulse with a new value mid-conversion → ignored, result unchanged.
- Assert reset_n=0 at step 3 of a conversion of 0xFF → busy=0, bcd_out=0 immediately; no done pulse; next start converts normally.
- bcd_oe=0 → bcd_out and sign_out all Z while busy and done still toggle; bcd_oe=1 afterwards → held result appears.

Source files
------------

// File: rtl/seq_bin_to_bcd_if.sv
// rtl/seq_bin_to_bcd_if.sv - start/busy/done handshake and shared BCD display bus
//
// Groups the converter's request, status and display-bus signals.
//   start    : request a conversion of bin_in (master -> slave)
//   bin_in   : binary operand, BIN_WIDTH bits (master -> slave)
//   bcd_oe   : output enable for bcd_out / sign_out (master -> slave)
//   busy     : conversion in progress (slave -> master)
//   done     : one-cycle result-valid pulse (slave -> master)
//   sign_out : captured operand was negative; tri-stated when bcd_oe=0
//   bcd_out  : packed BCD, digit 0 in [3:0]; tri-stated when bcd_oe=0
// sign_out and bcd_out are nets so several converters can share one display bus.
interface seq_bin_to_bcd_if #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = (BIN_WIDTH * 301) / 1000 + 1
);
    logic                  start;
    logic [BIN_WIDTH-1:0]  bin_in;
    logic                  bcd_oe;
    logic                  busy;
    logic                  done;
    wire                   sign_out;
    wire  [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        output bcd_oe,
        input  busy,
        input  done,
        input  sign_out,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        input  bcd_oe,
        output busy,
        output done,
        output sign_out,
        output bcd_out
    );
endinterface

// File: rtl/seq_bin_to_bcd.sv
// rtl/seq_bin_to_bcd.sv - multi-cycle shift-add-3 binary to BCD converter
//
// Converts bin_in to packed BCD over BIN_WIDTH/SHIFTS_PER_CYCLE clock edges.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : seq_bin_to_bcd_if.slave
//             start/bin_in/bcd_oe in, busy/done/sign_out/bcd_out out
// Parameters:
//   BIN_WIDTH        : operand width (>= 2)
//   DIGITS           : BCD digits produced; fewer than needed truncates the top
//   SHIFTS_PER_CYCLE : double-dabble steps per clock; must divide BIN_WIDTH
//   SIGNED_MODE      : 1 converts the magnitude of a two's complement operand
module seq_bin_to_bcd #(
    parameter int BIN_WIDTH        = 8,
    parameter int DIGITS           = (BIN_WIDTH * 301) / 1000 + 1,
    parameter int SHIFTS_PER_CYCLE = 1,
    parameter int SIGNED_MODE      = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    seq_bin_to_bcd_if.slave   bus
);
    localparam int SCRATCH_W = 4 * DIGITS;
    localparam int CNT_W     = $clog2(BIN_WIDTH + 1);
    // Guarded divisor keeps the rate check itself free of a modulo by zero.
    localparam int SAFE_SPC  = (SHIFTS_PER_CYCLE < 1) ? 1 : SHIFTS_PER_CYCLE;

    generate
        if (BIN_WIDTH < 2) begin : gBadWidth
            $error("seq_bin_to_bcd: BIN_WIDTH must be at least 2");
        end
        if ((SHIFTS_PER_CYCLE < 1) || ((BIN_WIDTH % SAFE_SPC) != 0)) begin : gBadRate
            $error("seq_bin_to_bcd: SHIFTS_PER_CYCLE must divide BIN_WIDTH");
        end
    endgenerate

    // FINISH names the completion point; it is folded into the last SHIFT edge
    // rather than costing a cycle, so the register never actually holds it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } stateT;

    stateT                  state;
    logic                   busyReg;
    logic                   doneReg;
    logic [SCRATCH_W-1:0]   resultReg;
    logic                   signReg;
    logic                   pendingSign;
    logic [SCRATCH_W-1:0]   scratchReg;
    logic [BIN_WIDTH-1:0]   operandReg;
    logic [CNT_W-1:0]       stepCnt;

    logic                   negIn;
    logic [BIN_WIDTH-1:0]   magIn;
    logic [SCRATCH_W-1:0]   nextScratch;
    logic [BIN_WIDTH-1:0]   nextOperand;
    logic [CNT_W-1:0]       nextCnt;
    logic                   lastStep;

    // Magnitude is taken as an unsigned BIN_WIDTH value, so the most negative
    // input wraps to exactly 2^(BIN_WIDTH-1) instead of overflowing.
    always_comb begin
        negIn = (SIGNED_MODE != 0) ? bus.bin_in[BIN_WIDTH-1] : 1'b0;
        magIn = negIn ? (~bus.bin_in + BIN_WIDTH'(1)) : bus.bin_in;
    end

    // SHIFTS_PER_CYCLE chained double-dabble steps: correct every digit >= 5,
    // then shift the operand MSB into the scratch LSB. Digit adds wrap mod 16
    // and the shift drops the scratch MSB when DIGITS is undersized.
    always_comb begin
        nextScratch = scratchReg;
        nextOperand = operandReg;
        for (int s = 0; s < SHIFTS_PER_CYCLE; s++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (nextScratch[4*d +: 4] >= 4'd5) begin
                    nextScratch[4*d +: 4] = nextScratch[4*d +: 4] + 4'd3;
                end
            end
            nextScratch = {nextScratch[SCRATCH_W-2:0], nextOperand[BIN_WIDTH-1]};
            nextOperand = {nextOperand[BIN_WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        nextCnt  = stepCnt + CNT_W'(SHIFTS_PER_CYCLE);
        lastStep = (nextCnt == CNT_W'(BIN_WIDTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
            resultReg   <= '0;
            signReg     <= 1'b0;
            pendingSign <= 1'b0;
            scratchReg  <= '0;
            operandReg  <= '0;
            stepCnt     <= '0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        operandReg  <= magIn;
                        pendingSign <= negIn;
                        scratchReg  <= '0;
                        stepCnt     <= '0;
                        busyReg     <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratchReg <= nextScratch;
                    operandReg <= nextOperand;
                    stepCnt    <= nextCnt;
                    if (lastStep) begin
                        // Whole result and sign load together on the final
                        // step; the visible result never shows partial work.
                        resultReg <= nextScratch;
                        signReg   <= pendingSign;
                        doneReg   <= 1'b1;
                        busyReg   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busyReg;
    assign bus.done     = doneReg;
    assign bus.sign_out = bus.bcd_oe ? signReg   : 1'bz;
    assign bus.bcd_out  = bus.bcd_oe ? resultReg : {SCRATCH_W{1'bz}};
endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// tb/tb_seq_bin_to_bcd.sv - self-checking bench for seq_bin_to_bcd
module tb_seq_bin_to_bcd;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    seq_bin_to_bcd_if #(.BIN_WIDTH(8))  ifU8 ();
    seq_bin_to_bcd_if #(.BIN_WIDTH(8))  ifS8 ();
    seq_bin_to_bcd_if #(.BIN_WIDTH(16)) ifW16 ();

    seq_bin_to_bcd #(.BIN_WIDTH(8), .SHIFTS_PER_CYCLE(1), .SIGNED_MODE(0)) dutU8 (
        .clk(clk), .reset_n(reset_n), .bus(ifU8.slave));
    seq_bin_to_bcd #(.BIN_WIDTH(8), .SHIFTS_PER_CYCLE(1), .SIGNED_MODE(1)) dutS8 (
        .clk(clk), .reset_n(reset_n), .bus(ifS8.slave));
    seq_bin_to_bcd #(.BIN_WIDTH(16), .SHIFTS_PER_CYCLE(4), .SIGNED_MODE(0)) dutW16 (
        .clk(clk), .reset_n(reset_n), .bus(ifW16.slave));

    typedef struct {
        logic [19:0] bcd;
        logic        sign;
    } expT;

    typedef struct {
        int          sel;
        logic [15:0] val;
        logic [19:0] bcd;
        logic        sign;
    } vecT;

    expT q0[$];
    expT q1[$];
    expT q2[$];
    vecT vecs[$];

    int errors = 0;
    int checks = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endfunction

    // A disabled bus reads z in a 4-state simulator and 0 in a 2-state one.
    function automatic void checkFloat(string name, logic [19:0] v, int width);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < width; i++) begin
            if (!((v[i] === 1'bz) || (v[i] === 1'b0))) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: actual=%h required=all z", name, v);
        end
    endfunction

    function automatic logic [19:0] refBcd(int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic getBusy(int sel);
        case (sel)
            0:       return ifU8.busy;
            1:       return ifS8.busy;
            default: return ifW16.busy;
        endcase
    endfunction

    function automatic logic getDone(int sel);
        case (sel)
            0:       return ifU8.done;
            1:       return ifS8.done;
            default: return ifW16.done;
        endcase
    endfunction

    function automatic logic [19:0] getBcd(int sel);
        case (sel)
            0:       return {8'h0, ifU8.bcd_out};
            1:       return {8'h0, ifS8.bcd_out};
            default: return ifW16.bcd_out;
        endcase
    endfunction

    function automatic void pushExp(int sel, expT e);
        case (sel)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qSize(int sel);
        case (sel)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void setStart(int sel, logic s, logic [15:0] v);
        case (sel)
            0:       begin ifU8.start = s;  ifU8.bin_in  = v[7:0]; end
            1:       begin ifS8.start = s;  ifS8.bin_in  = v[7:0]; end
            default: begin ifW16.start = s; ifW16.bin_in = v;      end
        endcase
    endfunction

    function automatic void scoreOut(int sel, logic [19:0] bcd, logic sign, logic oe, int width);
        expT e;
        logic have;
        have = 1'b0;
        case (sel)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut%0d: actual done=1 required done=0", sel);
        end else if (oe) begin
            check($sformatf("bcd_out dut%0d", sel), bcd, e.bcd);
            check($sformatf("sign_out dut%0d", sel), sign, e.sign);
        end else begin
            checkFloat($sformatf("bcd_out_z dut%0d", sel), bcd, width);
            checkFloat($sformatf("sign_out_z dut%0d", sel), {19'h0, sign}, 1);
        end
    endfunction

    always @(negedge clk) begin
        if (ifU8.done === 1'b1)  scoreOut(0, {8'h0, ifU8.bcd_out}, ifU8.sign_out, ifU8.bcd_oe, 12);
        if (ifS8.done === 1'b1)  scoreOut(1, {8'h0, ifS8.bcd_out}, ifS8.sign_out, ifS8.bcd_oe, 12);
        if (ifW16.done === 1'b1) scoreOut(2, ifW16.bcd_out, ifW16.sign_out, ifW16.bcd_oe, 20);
    end

    task automatic launch(int sel, logic [15:0] val, logic [19:0] bcd, logic sign);
        expT e;
        e.bcd  = bcd;
        e.sign = sign;
        @(negedge clk);
        setStart(sel, 1'b1, val);
        pushExp(sel, e);
        @(negedge clk);
        setStart(sel, 1'b0, val);
    endtask

    task automatic waitDrain(int sel);
        int n;
        n = 0;
        while ((qSize(sel) > 0) && (n < 60)) begin
            @(negedge clk);
            n++;
        end
        if (qSize(sel) > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: actual pending=%0d required pending=0", sel, qSize(sel));
            case (sel)
                0:       q0.delete();
                1:       q1.delete();
                default: q2.delete();
            endcase
        end
        @(negedge clk);
    endtask

    // Counts busy cycles and the done position relative to the accepting edge.
    task automatic latencyRun(int sel, logic [15:0] val, logic [19:0] bcd, int steps);
        expT e;
        int busyCnt, doneAt, doneCnt;
        busyCnt = 0; doneAt = 0; doneCnt = 0;
        e.bcd = bcd;
        e.sign = 1'b0;
        @(negedge clk);
        setStart(sel, 1'b1, val);
        pushExp(sel, e);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) setStart(sel, 1'b0, val);
            if (getBusy(sel)) busyCnt++;
            if (getDone(sel)) begin
                doneCnt++;
                if (doneAt == 0) doneAt = k;
            end
        end
        check($sformatf("busy_cycles dut%0d", sel), busyCnt, steps);
        check($sformatf("done_position dut%0d", sel), doneAt, steps + 1);
        check($sformatf("done_pulses dut%0d", sel), doneCnt, 1);
    endtask

    initial begin
        int firstAt, secondAt, doneCnt, busyCnt, doneAt;
        logic [15:0] v;

        vecs.push_back('{0, 16'h00FF, 20'h00255, 1'b0});
        vecs.push_back('{0, 16'h0000, 20'h00000, 1'b0});
        vecs.push_back('{0, 16'h0063, 20'h00099, 1'b0});
        vecs.push_back('{0, 16'h000A, 20'h00010, 1'b0});
        vecs.push_back('{0, 16'h0009, 20'h00009, 1'b0});
        vecs.push_back('{0, 16'h0064, 20'h00100, 1'b0});
        vecs.push_back('{0, 16'h0080, 20'h00128, 1'b0});
        vecs.push_back('{1, 16'h0080, 20'h00128, 1'b1});
        vecs.push_back('{1, 16'h007F, 20'h00127, 1'b0});
        vecs.push_back('{1, 16'h00FF, 20'h00001, 1'b1});
        vecs.push_back('{1, 16'h0000, 20'h00000, 1'b0});
        vecs.push_back('{1, 16'h009C, 20'h00100, 1'b1});
        vecs.push_back('{2, 16'hFFFF, 20'h65535, 1'b0});
        vecs.push_back('{2, 16'h0000, 20'h00000, 1'b0});
        vecs.push_back('{2, 16'h2710, 20'h10000, 1'b0});
        vecs.push_back('{2, 16'h04D2, 20'h01234, 1'b0});
        vecs.push_back('{2, 16'h270F, 20'h09999, 1'b0});

        reset_n = 1'b0;
        setStart(0, 1'b0, 16'h0);
        setStart(1, 1'b0, 16'h0);
        setStart(2, 1'b0, 16'h0);
        ifU8.bcd_oe = 1'b1;
        ifS8.bcd_oe = 1'b1;
        ifW16.bcd_oe = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset_busy dut%0d", s), getBusy(s), 1'b0);
            check($sformatf("reset_done dut%0d", s), getDone(s), 1'b0);
            check($sformatf("reset_bcd dut%0d", s), getBcd(s), 20'h0);
        end
        check("reset_sign dut1", ifS8.sign_out, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            launch(vecs[i].sel, vecs[i].val, vecs[i].bcd, vecs[i].sign);
            waitDrain(vecs[i].sel);
        end

        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom_range(0, 255));
            launch(0, v, refBcd(v), 1'b0);
            waitDrain(0);
            v = 16'($urandom_range(0, 255));
            launch(1, v, refBcd((v >= 128) ? (256 - v) : v), v[7]);
            waitDrain(1);
            v = 16'($urandom_range(0, 65535));
            launch(2, v, refBcd(v), 1'b0);
            waitDrain(2);
        end

        latencyRun(0, 16'h00FF, 20'h00255, 8);
        latencyRun(2, 16'hFFFF, 20'h65535, 4);

        // Back-to-back: second start issued in the first done cycle.
        firstAt = 0; secondAt = 0;
        @(negedge clk);
        setStart(0, 1'b1, 16'h0000);
        pushExp(0, '{20'h00000, 1'b0});
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if ((k == 1) || ((firstAt != 0) && (k == firstAt + 1))) setStart(0, 1'b0, 16'h0063);
            if (ifU8.done) begin
                if (firstAt == 0) begin
                    firstAt = k;
                    setStart(0, 1'b1, 16'h0063);
                    pushExp(0, '{20'h00099, 1'b0});
                end else if (secondAt == 0) begin
                    secondAt = k;
                end
            end
        end
        check("b2b_first_done", firstAt, 9);
        check("b2b_period", secondAt - firstAt, 9);
        waitDrain(0);

        // Start pulse mid-conversion is ignored; bin_in changes have no effect.
        doneCnt = 0; doneAt = 0;
        @(negedge clk);
        setStart(2, 1'b1, 16'hFFFF);
        pushExp(2, '{20'h65535, 1'b0});
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) setStart(2, 1'b0, 16'hFFFF);
            if (k == 2) setStart(2, 1'b1, 16'h1234);
            if (k == 3) setStart(2, 1'b0, 16'h0001);
            if (ifW16.done) begin
                doneCnt++;
                if (doneAt == 0) doneAt = k;
            end
        end
        check("midstart_done_position", doneAt, 5);
        check("midstart_done_pulses", doneCnt, 1);
        check("midstart_held_result", ifW16.bcd_out, 20'h65535);

        // Reset during a conversion aborts it and clears the result.
        launch(0, 16'h00C8, 20'h00200, 1'b0);
        waitDrain(0);
        @(negedge clk);
        setStart(0, 1'b1, 16'h00FF);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) setStart(0, 1'b0, 16'h00FF);
        end
        check("pre_reset_busy", ifU8.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", ifU8.busy, 1'b0);
        check("abort_done", ifU8.done, 1'b0);
        check("abort_bcd", ifU8.bcd_out, 12'h000);
        @(negedge clk);
        reset_n = 1'b1;
        doneCnt = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (ifU8.done) doneCnt++;
        end
        check("abort_no_done", doneCnt, 0);
        launch(0, 16'h002A, 20'h00042, 1'b0);
        waitDrain(0);
        check("after_abort_result", ifU8.bcd_out, 12'h042);

        // Output enable off: bus floats while the handshake keeps running.
        ifS8.bcd_oe = 1'b0;
        #1;
        checkFloat("oe_off_idle_bcd", {8'h0, ifS8.bcd_out}, 12);
        busyCnt = 0; doneCnt = 0;
        @(negedge clk);
        setStart(1, 1'b1, 16'h0080);
        pushExp(1, '{20'h00128, 1'b1});
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) setStart(1, 1'b0, 16'h0080);
            if (ifS8.busy) busyCnt++;
            if (ifS8.done) doneCnt++;
        end
        check("oe_off_busy_cycles", busyCnt, 8);
        check("oe_off_done_pulses", doneCnt, 1);
        ifS8.bcd_oe = 1'b1;
        #1;
        check("oe_on_held_bcd", ifS8.bcd_out, 12'h128);
        check("oe_on_held_sign", ifS8.sign_out, 1'b1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
